avg_dc_block_mc: RTL and testbench

//  Multi-channel sliding-window DC remover for the demodulator datapath (e.g. I/Q pair after mixing).

---
 rtl/avg_dc_block_mc.sv | 189 ++++++++++++++++++
 tb/tb_avg_dc_block_mc.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_dc_block_mc.sv
// Multi-channel sliding-window DC remover.
// Each channel keeps the last 2^LOG2_N accepted samples in a small RAM and a
// running sum. The output is the bypassed sample, the DC-removed sample
// (saturated) or the window mean, selected per sample by mode_i.
//
// Handshake: a sample is accepted on a rising clk edge when valid_i and
// ready_o are both high and clear_i is low. ready_o is high only in RUN.
// valid_i while ready_o is low is ignored. valid_o is a one-cycle strobe per
// accepted sample, two cycles after the accepting edge, with no backpressure.
//
// Pipeline: accept edge  -> old slot read, new sample written, ptr advanced
//           stage 1 edge -> running sum updated (includes current sample)
//           stage 2 edge -> mean / subtract / saturate registered to outputs
module avg_dc_block_mc #(
    parameter int WIDTH    = 16,
    parameter int LOG2_N   = 7,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic [1:0]                mode_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    output logic                      valid_o,
    output logic [CHANNELS*WIDTH-1:0] data_o,
    output logic [CHANNELS*WIDTH-1:0] mean_o,
    output logic                      settled_o
);
    localparam int N  = 1 << LOG2_N;
    localparam int SW = WIDTH + LOG2_N;
    localparam logic [LOG2_N-1:0] ADDR_LAST = LOG2_N'(N - 1);
    localparam logic [LOG2_N:0]   FILL_FULL = (LOG2_N + 1)'(N);
    localparam logic [LOG2_N:0]   FILL_LAST = (LOG2_N + 1)'(N - 1);

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_MEAN   = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                    state;
    logic [LOG2_N-1:0]         clr_addr;
    logic [LOG2_N-1:0]         ptr;
    logic [LOG2_N:0]           fill;
    logic                      accept;
    logic                      p1_valid;
    logic                      p2_valid;
    logic [1:0]                p1_mode;
    logic [1:0]                p2_mode;
    logic [CHANNELS*WIDTH-1:0] p1_x;
    logic [CHANNELS*WIDTH-1:0] p2_x;
    logic [CHANNELS*WIDTH-1:0] mean_w;
    logic [CHANNELS*WIDTH-1:0] res_w;

    // clear_i beats a coincident sample
    assign accept = valid_i && ready_o && !clear_i;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic signed [WIDTH-1:0] win_mem [N];
        logic signed [WIDTH-1:0] old_q;
        logic signed [WIDTH-1:0] x_in;
        logic signed [WIDTH-1:0] x1;
        logic signed [WIDTH-1:0] x2;
        logic signed [WIDTH-1:0] mean_c;
        logic signed [WIDTH-1:0] sat_c;
        logic signed [WIDTH-1:0] res_c;
        logic signed [SW-1:0]    sum_q;
        logic signed [WIDTH:0]   diff_c;

        assign x_in = data_i[g*WIDTH +: WIDTH];
        assign x1   = p1_x[g*WIDTH +: WIDTH];
        assign x2   = p2_x[g*WIDTH +: WIDTH];

        // Window RAM: zero sweep while clearing, sample write on a non-freeze accept
        always_ff @(posedge clk) begin
            if (rst) begin
                if (state == ST_CLEAR)
                    win_mem[clr_addr] <= '0;
                else if (accept && mode_i != MODE_FREEZE)
                    win_mem[ptr] <= x_in;
            end
        end

        // Capture the slot about to be overwritten (pre-write value)
        always_ff @(posedge clk) begin
            if (accept)
                old_q <= win_mem[ptr];
        end

        // Running sum: add the new sample, drop the one leaving the window
        always_ff @(posedge clk) begin
            if (!rst || clear_i)
                sum_q <= '0;
            else if (p1_valid && p1_mode != MODE_FREEZE)
                sum_q <= sum_q + {{LOG2_N{x1[WIDTH-1]}}, x1}
                               - {{LOG2_N{old_q[WIDTH-1]}}, old_q};
        end

        // Floor mean is the top WIDTH bits of the sum (arithmetic shift by LOG2_N)
        assign mean_c = sum_q[SW-1:LOG2_N];
        assign diff_c = {x2[WIDTH-1], x2} - {mean_c[WIDTH-1], mean_c};
        assign sat_c  = (diff_c[WIDTH] != diff_c[WIDTH-1])
                      ? (diff_c[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                      : diff_c[WIDTH-1:0];

        // Per-sample result selection by the mode that travelled with the sample
        always_comb begin
            res_c = sat_c;
            case (p2_mode)
                MODE_BYPASS: res_c = x2;
                MODE_MEAN:   res_c = mean_c;
                default:     res_c = sat_c;
            endcase
        end

        assign mean_w[g*WIDTH +: WIDTH] = mean_c;
        assign res_w[g*WIDTH +: WIDTH]  = res_c;
    end

    // Control: CLEAR/RUN FSM, write pointer, pipeline valids and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            ready_o   <= 1'b0;
            ptr       <= '0;
            fill      <= '0;
            settled_o <= 1'b0;
            p1_valid  <= 1'b0;
            p2_valid  <= 1'b0;
            p1_mode   <= '0;
            p2_mode   <= '0;
            p1_x      <= '0;
            p2_x      <= '0;
            valid_o   <= 1'b0;
            data_o    <= '0;
            mean_o    <= '0;
        end else if (clear_i) begin
            // restart the zero sweep and flush anything in flight
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            ready_o   <= 1'b0;
            ptr       <= '0;
            fill      <= '0;
            settled_o <= 1'b0;
            p1_valid  <= 1'b0;
            p2_valid  <= 1'b0;
            valid_o   <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
                if (clr_addr == ADDR_LAST) begin
                    state   <= ST_RUN;
                    ready_o <= 1'b1;
                end
            end

            p1_valid <= accept;
            if (accept) begin
                p1_x    <= data_i;
                p1_mode <= mode_i;
                if (mode_i != MODE_FREEZE)
                    ptr <= ptr + 1'b1;
            end

            p2_valid <= p1_valid;
            if (p1_valid) begin
                p2_x    <= p1_x;
                p2_mode <= p1_mode;
            end

            valid_o <= p2_valid;
            if (p2_valid) begin
                data_o <= res_w;
                mean_o <= mean_w;
                if (p2_mode != MODE_FREEZE && fill != FILL_FULL) begin
                    fill      <= fill + 1'b1;
                    settled_o <= (fill == FILL_LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_avg_dc_block_mc.sv
// Bench for avg_dc_block_mc with WIDTH=16, LOG2_N=3, CHANNELS=2.
// A window model predicts each output when a sample is driven; the monitor
// pops predictions on valid_o and also checks the two-cycle latency.
module tb_avg_dc_block_mc;
    localparam int WIDTH    = 16;
    localparam int LOG2_N   = 3;
    localparam int CHANNELS = 2;
    localparam int N        = 8;
    localparam int EW       = 97;   // {cycle[32], settled, mean[32], data[32]}

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        clear_i = 1'b0;
    logic [1:0]  mode_i  = 2'b00;
    logic        valid_i = 1'b0;
    logic [31:0] data_i  = '0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic [31:0] mean_o;
    logic        settled_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    int m_win [2][8];
    int m_sum [2];
    int m_ptr;
    int m_fill;

    avg_dc_block_mc #(
        .WIDTH   (WIDTH),
        .LOG2_N  (LOG2_N),
        .CHANNELS(CHANNELS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (clear_i),
        .mode_i   (mode_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .mean_o   (mean_o),
        .settled_o(settled_o)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: valid_o=1 at cycle %0d, required no output", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                n_vec += 4;
                if (data_o !== mon_e[31:0]) begin
                    n_err++;
                    $display("FAIL data_o: got %h, required %h (cycle %0d)", data_o, mon_e[31:0], cyc);
                end
                if (mean_o !== mon_e[63:32]) begin
                    n_err++;
                    $display("FAIL mean_o: got %h, required %h (cycle %0d)", mean_o, mon_e[63:32], cyc);
                end
                if (settled_o !== mon_e[64]) begin
                    n_err++;
                    $display("FAIL settled_o: got %b, required %b (cycle %0d)", settled_o, mon_e[64], cyc);
                end
                if (cyc != int'(mon_e[96:65])) begin
                    n_err++;
                    $display("FAIL latency: valid_o at cycle %0d, required cycle %0d", cyc, int'(mon_e[96:65]));
                end
            end
        end
    end

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_sum[c] = 0;
            for (int i = 0; i < N; i++) m_win[c][i] = 0;
        end
        m_ptr  = 0;
        m_fill = 0;
    endtask

    task automatic model_accept(input int a, input int b, input logic [1:0] m);
        logic [31:0] dpk;
        logic [31:0] mpk;
        int x, mean, diff, res;
        dpk = '0;
        mpk = '0;
        for (int c = 0; c < 2; c++) begin
            x = (c == 0) ? a : b;
            if (m != 2'b11) begin
                m_sum[c] = m_sum[c] + x - m_win[c][m_ptr];
                m_win[c][m_ptr] = x;
            end
            mean = m_sum[c] >>> LOG2_N;
            diff = x - mean;
            if (diff > 32767) diff = 32767;
            else if (diff < -32768) diff = -32768;
            res = (m == 2'b00) ? x : (m == 2'b10) ? mean : diff;
            dpk[c*16 +: 16] = res[15:0];
            mpk[c*16 +: 16] = mean[15:0];
        end
        if (m != 2'b11) begin
            m_ptr = (m_ptr + 1) % N;
            if (m_fill < N) m_fill++;
        end
        exp_q.push_back({32'(cyc + 3), (m_fill == N), mpk, dpk});
    endtask

    // driver: present one sample for one edge (valid stays high for back-to-back calls)
    task automatic send(input int a, input int b, input logic [1:0] m);
        int guard;
        guard = 0;
        while (ready_o !== 1'b1 && guard < 50) begin
            valid_i = 1'b0;
            @(posedge clk); #1;
            guard++;
        end
        if (ready_o !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL send_ready: ready_o=%b, required 1 within 50 cycles", ready_o);
        end else begin
            data_i  = {b[15:0], a[15:0]};
            mode_i  = m;
            valid_i = 1'b1;
            model_accept(a, b, m);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int guard;
        valid_i = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d outputs missing, required 0", exp_q.size());
        end
        exp_q.delete();
        idle(2);
    endtask

    task automatic do_clear();
        valid_i = 1'b0;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int lows;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({ready_o, valid_o, settled_o, data_o, mean_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b vld=%b set=%b data=%h mean=%h, required all 0",
                     ready_o, valid_o, settled_o, data_o, mean_o);
        end
        rst = 1'b1;
        model_reset();
        lows = 0;
        while (ready_o !== 1'b1 && lows < 40) begin
            n_vec++;
            if ({valid_o, settled_o, data_o, mean_o} !== '0) begin
                n_err++;
                $display("FAIL clear_outputs: vld=%b set=%b data=%h mean=%h, required all 0",
                         valid_o, settled_o, data_o, mean_o);
            end
            lows++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (lows != N) begin
            n_err++;
            $display("FAIL reset_ready_low: ready_o low for %0d cycles, required %0d", lows, N);
        end
    endtask

    task automatic test_dc_removal();
        for (int i = 0; i < 10; i++) send(1000, 0, 2'b01);
        drain();
        n_vec++;
        if (settled_o !== 1'b1) begin
            n_err++;
            $display("FAIL dc_settled: settled_o=%b, required 1", settled_o);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 0; i < N; i++) send(0, 32767, 2'b01);
        send(0, -32768, 2'b01);
        drain();
        n_vec += 2;
        if (mean_o[31:16] !== 16'd24575) begin
            n_err++;
            $display("FAIL sat_mean: ch1 mean %0d, required 24575", $signed(mean_o[31:16]));
        end
        if (data_o[31:16] !== 16'h8000) begin
            n_err++;
            $display("FAIL sat_data: ch1 data %0d, required -32768", $signed(data_o[31:16]));
        end
    endtask

    task automatic test_freeze();
        do_clear();
        for (int i = 0; i < N; i++) send(1000, 0, 2'b01);
        for (int i = 0; i < 4; i++) send(5000, 0, 2'b11);
        drain();
        n_vec += 2;
        if (data_o[15:0] !== 16'd4000) begin
            n_err++;
            $display("FAIL freeze_data: ch0 data %0d, required 4000", $signed(data_o[15:0]));
        end
        if (mean_o[15:0] !== 16'd1000) begin
            n_err++;
            $display("FAIL freeze_mean: ch0 mean %0d, required 1000", $signed(mean_o[15:0]));
        end
        send(5000, 0, 2'b01);
        drain();
    endtask

    task automatic test_bypass();
        int a, b;
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 65535)) - 32768;
            send(a, b, 2'b00);
        end
        for (int i = 0; i < 3; i++) send(-500, 700, 2'b01);
        drain();
    endtask

    task automatic test_clear_inflight();
        int lows;
        send(1000, 1000, 2'b01);
        send(1000, 1000, 2'b01);
        // two samples in flight; clear arrives together with a sample that must be dropped
        data_i  = {16'd7, 16'd9};
        mode_i  = 2'b01;
        valid_i = 1'b1;
        clear_i = 1'b1;
        model_reset();
        exp_q.delete();
        @(posedge clk); #1;
        clear_i = 1'b0;
        lows = 0;
        while (ready_o !== 1'b1 && lows < 40) begin
            n_vec++;
            if (settled_o !== 1'b0) begin
                n_err++;
                $display("FAIL clear_settled: settled_o=%b, required 0", settled_o);
            end
            lows++;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        n_vec++;
        if (lows != N) begin
            n_err++;
            $display("FAIL clear_ready_low: ready_o low for %0d cycles, required %0d", lows, N);
        end
        send(1000, 0, 2'b01);
        drain();
        n_vec++;
        if (data_o[15:0] !== 16'd875) begin
            n_err++;
            $display("FAIL clear_restart: ch0 data %0d, required 875", $signed(data_o[15:0]));
        end
    endtask

    task automatic test_back_to_back();
        int a, b;
        logic [1:0] m;
        for (int i = 0; i < 12; i++) begin
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 65535)) - 32768;
            m = 2'($urandom_range(0, 3));
            send(a, b, m);
        end
        drain();
    endtask

    task automatic test_gaps_wrap();
        int a, b;
        do_clear();
        for (int i = 0; i < 3 * N; i++) begin
            idle(int'($urandom_range(0, 3)));
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 4000)) - 2000;
            send(a, b, 2'b10);
        end
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_dc_removal();
        test_saturation();
        test_freeze();
        test_bypass();
        test_clear_inflight();
        test_back_to_back();
        test_gaps_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
